// File: rtl/marine_radar_pkg.sv
// Shared types and widths for the marine radar pulse gate and its trigger detector.
package marine_radar_pkg;

    localparam int unsigned TRIG_W = 12;
    localparam int unsigned SAMP_W = 16;
    localparam int unsigned LAT_W  = 32;
    localparam int unsigned TCNT_W = 32;

    typedef enum logic {
        ARMED,
        EXCITED
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        CAPTURE
    } cap_state_t;

endpackage

// File: rtl/marine_radar_pulse_gate_detector.sv
// Hysteresis trigger detector: fires on excite crossing, re-arms below relax once the
// lockout latency has expired. Reusable for ARP/ACP channels.
module hysteresis_detector
    import marine_radar_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              strobe_i,
    input  logic [TRIG_W-1:0] sample_i,
    input  logic [TRIG_W-1:0] excite_i,
    input  logic [TRIG_W-1:0] relax_i,
    input  logic [LAT_W-1:0]  latency_i,
    output logic              fire_o,
    output logic              pulse_o
);

    det_state_t       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             pulse_q;

    always_comb begin
        state_d = state_q;
        lat_d   = (lat_q != '0) ? lat_q - LAT_W'(1) : '0;
        fire_o  = 1'b0;
        if (!enable_i) begin
            state_d = ARMED;
            lat_d   = '0;
        end else if (strobe_i) begin
            case (state_q)
                ARMED: begin
                    if (sample_i >= excite_i) begin
                        state_d = EXCITED;
                        lat_d   = latency_i;
                        fire_o  = 1'b1;
                    end
                end
                EXCITED: begin
                    if (lat_q == '0 && sample_i <= relax_i) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARMED;
            lat_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            pulse_q <= fire_o;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/marine_radar_pulse_gate.sv
// Radar pulse gate: detects trigger, skips trig_delay strobes, then gates n_samples
// video samples with first/last markers. All outputs registered.
module marine_radar_pulse_gate
    import marine_radar_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              strobe,
    input  logic [TRIG_W-1:0] trig_in,
    input  logic [SAMP_W-1:0] vid_in,
    input  logic [TRIG_W-1:0] trig_thresh_excite,
    input  logic [TRIG_W-1:0] trig_thresh_relax,
    input  logic [LAT_W-1:0]  trig_latency,
    input  logic [SAMP_W-1:0] trig_delay,
    input  logic [SAMP_W-1:0] n_samples,
    output logic              trig_pulse,
    output logic [SAMP_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last,
    output logic [TCNT_W-1:0] trig_count,
    output logic [SAMP_W-1:0] missed_count
);

    logic fire;

    hysteresis_detector u_det (
        .clk_i     (clock),
        .rst_i     (reset),
        .enable_i  (enable),
        .strobe_i  (strobe),
        .sample_i  (trig_in),
        .excite_i  (trig_thresh_excite),
        .relax_i   (trig_thresh_relax),
        .latency_i (trig_latency),
        .fire_o    (fire),
        .pulse_o   (trig_pulse)
    );

    cap_state_t        cap_q, cap_d;
    logic [SAMP_W-1:0] dly_q, dly_d;
    logic [SAMP_W-1:0] idx_q, idx_d;
    logic [SAMP_W-1:0] nsamp_q, nsamp_d;
    logic [SAMP_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [SAMP_W-1:0] miss_q, miss_d;

    // Capture reacts to the detector's combinational fire, so it leaves IDLE on the
    // triggering strobe's edge and the very next strobe is the first post-trigger one.
    always_comb begin
        cap_d   = cap_q;
        dly_d   = dly_q;
        idx_d   = idx_q;
        nsamp_d = nsamp_q;
        data_d  = data_q;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        tcnt_d  = tcnt_q;
        miss_d  = miss_q;

        if (fire) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            if (cap_q != IDLE && miss_q != '1) begin
                miss_d = miss_q + SAMP_W'(1);
            end
        end

        if (!enable) begin
            cap_d = IDLE;
        end else begin
            case (cap_q)
                IDLE: begin
                    if (fire && n_samples != '0) begin
                        nsamp_d = n_samples;
                        idx_d   = '0;
                        dly_d   = trig_delay;
                        cap_d   = (trig_delay == '0) ? CAPTURE : DELAY;
                    end
                end
                DELAY: begin
                    if (strobe) begin
                        dly_d = dly_q - SAMP_W'(1);
                        if (dly_q == SAMP_W'(1)) begin
                            cap_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (strobe) begin
                        valid_d = 1'b1;
                        data_d  = vid_in;
                        first_d = (idx_q == '0);
                        last_d  = (idx_q == nsamp_q - SAMP_W'(1));
                        idx_d   = idx_q + SAMP_W'(1);
                        if (idx_q == nsamp_q - SAMP_W'(1)) begin
                            cap_d = IDLE;
                        end
                    end
                end
                default: cap_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_q   <= IDLE;
            dly_q   <= '0;
            idx_q   <= '0;
            nsamp_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            tcnt_q  <= '0;
            miss_q  <= '0;
        end else begin
            cap_q   <= cap_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            nsamp_q <= nsamp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            miss_q  <= miss_d;
        end
    end

    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign out_first    = first_q;
    assign out_last     = last_q;
    assign trig_count   = tcnt_q;
    assign missed_count = miss_q;

endmodule

// File: doc/marine_radar_pulse_gate.md
# marine_radar_pulse_gate

Downstream consumer of the radar master-control settings: detects the radar trigger pulse on the digitised trigger channel using hysteresis thresholds and a lockout latency, then waits a programmable delay and gates exactly `n_samples` video samples per pulse onto the RX sample stream with first/last markers. Sits between the RX DSP front end (decimated trigger and video samples) and the RX packetiser/FIFO, running in the master clock domain.

## Interface
- No parameters; all widths fixed.
- clock  in  1  master clock.
- reset  in  1  async active-high reset; tie to rx_dsp_reset.
- enable  in  1  enable_rx; low forces both FSMs idle (synchronous), counters retained.
- strobe  in  1  one-cycle sample-valid for `trig_in` and `vid_in`.
- trig_in  in  12  unsigned trigger-channel sample.
- vid_in  in  16  video sample (already negated if required upstream).
- trig_thresh_excite  in  12  trigger fires when `trig_in >= excite`.
- trig_thresh_relax  in  12  detector re-arms only when `trig_in <= relax`.
- trig_latency  in  32  minimum clocks from trigger to re-arm.
- trig_delay  in  16  strobes skipped after trigger before capture.
- n_samples  in  16  samples captured per pulse; 0 disables capture.
- trig_pulse  out  1  one-cycle trigger-detected pulse.
- out_data  out  16  gated video sample.
- out_valid  out  1  out_data valid.
- out_first  out  1  with out_valid, sample index 0.
- out_last  out  1  with out_valid, sample index n_samples-1.
- trig_count  out  32  triggers detected since reset, wraps.
- missed_count  out  16  triggers arriving while not IDLE, saturates at 0xFFFF.

## Operation
- Detector FSM (advances only on strobe, except latency counter): ARMED -> EXCITED when `trig_in >= excite`; emits trig_pulse, loads latency counter with `trig_latency`, increments trig_count. EXCITED -> ARMED when latency counter == 0 and a strobed `trig_in <= relax`. Latency counter decrements every clock, stops at 0.
- Capture FSM: IDLE, DELAY, CAPTURE. On trig_pulse in IDLE: if n_samples == 0 stay IDLE; else if trig_delay == 0 go CAPTURE; else DELAY with counter = trig_delay. DELAY: decrement per strobe; on reaching 0 go CAPTURE. CAPTURE: each strobe emits one sample, index 0..n_samples-1; after index n_samples-1 return IDLE.
- trig_pulse while DELAY/CAPTURE: ignored by capture FSM, missed_count increments (saturating).
- Settings sampled at trigger: trig_delay and n_samples latched when leaving IDLE; mid-sweep changes take effect next sweep. Thresholds and latency used live.
- enable low: detector -> ARMED, latency counter 0, capture -> IDLE, outputs valid/first/last 0. trig_count, missed_count hold.
- n_samples == 1: single sample with out_first and out_last both high.
- excite <= relax is legal; detector then toggles each eligible strobe subject to latency.

## Timing
- Reset values: trig_pulse 0, out_valid/first/last 0, out_data 0, trig_count 0, missed_count 0, detector ARMED, capture IDLE, all internal counters 0.
- trig_pulse high the clock after the strobe whose sample crosses excite (1-cycle latency).
- The triggering strobe is never captured. With delay D, the first captured sample is the (D+1)th strobe after the triggering strobe; out_valid appears 1 clock after that strobe.
- All outputs registered; no combinational input-to-output paths.
- Async reset mid-sweep: immediate return to reset values; no partial out_last.

## Structure
- Package `marine_radar_pkg`: detector state enum (ARMED, EXCITED), capture state enum (IDLE, DELAY, CAPTURE), width constants (12-bit trigger, 16-bit sample/count).
- Sub-module `hysteresis_detector` (strobe, sample, excite, relax, latency -> pulse); reusable later for ARP and ACP channels.

## Test plan
- excite=2000, relax=500, latency=0, delay=0, n=4; trig_in 0 -> 3000 on one strobe -> trig_pulse once, next 4 strobes emitted, first on index 0, last on index 3, trig_count=1.
- delay=3, n=2 -> strobes 1-3 after trigger dropped, strobes 4-5 output, out_last on 5th.
- latency=100, trig_in oscillating 3000/0 every strobe (strobe every 4 clocks) -> second trig_pulse not before 100 clocks after the first.
- n=10, retrigger at sample index 5 -> capture continues to index 9, missed_count=1, trig_count=2.
- n=0 with trigger -> trig_pulse and trig_count increment, no out_valid.
- Assert reset at index 2 of 8-sample sweep -> all outputs 0 immediately; after release new trigger starts fresh at index 0.
